demux_scan_ctrl: RTL and testbench

Sequential select generator that sits directly upstream of `demux_1xn`. It drives the demux `sel` and `in` ports and steps through a masked set of output channels, holding each for a programmable dwell time. It supports a single sweep or continuous looping, with a start/done handshake toward the controlling logic. It makes `demux_1xn` usable as a timed channel scanner without any host sequencing.

---
 rtl/demux_scan_pkg.sv | 10 +
 rtl/demux_scan_ctrl_next_chan.sv | 32 +++
 rtl/demux_scan_ctrl.sv | 114 +++++++++++
 tb/tb_demux_scan_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/demux_scan_pkg.sv
// demux_scan_pkg: shared FSM state type, default widths and channel-count helper for the demux scan controller.
package demux_scan_pkg;
    typedef enum logic {IDLE, SCAN} state_t;
    localparam int N_DEF       = 3;
    localparam int DWELL_W_DEF = 8;
    localparam int CH          = 2 ** N_DEF;
    function automatic int ch_count(input int n);
        return 2 ** n;
    endfunction
endpackage

// File: rtl/demux_scan_ctrl_next_chan.sv
// next_chan_find: combinational priority scan of a channel mask.
//   i_mask         - channel enables, bit i = channel i
//   i_sel          - current channel
//   o_next         - lowest enabled channel strictly above i_sel
//   o_found_higher - o_next is valid
//   o_lowest       - lowest enabled channel overall (wrap target)
module next_chan_find
    import demux_scan_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [2**N-1:0] i_mask,
    input  logic [N-1:0]    i_sel,
    output logic [N-1:0]    o_next,
    output logic            o_found_higher,
    output logic [N-1:0]    o_lowest
);
    localparam int NCH = ch_count(N);
    // Descending walk so the last hit is the lowest qualifying index.
    always_comb begin
        o_next         = '0;
        o_found_higher = 1'b0;
        o_lowest       = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_mask[i] && i > int'(i_sel)) begin
                o_next         = N'(i);
                o_found_higher = 1'b1;
            end
            if (i_mask[i]) o_lowest = N'(i);
        end
    end
endmodule

// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl: timed channel scanner driving demux_1xn sel/in over a masked channel set.
//   clk, rst   - clock, synchronous active-high reset
//   start/stop - sweep request (IDLE only) / abort (any state, wins over start)
//   loop       - wrap and repeat instead of a single sweep (latched at start)
//   dwell      - cycles per channel, 0 treated as 1 (latched at start)
//   mask       - channel enables (latched at start)
//   sel, in    - registered demux select and data
//   busy, done - scanning / one-cycle normal-completion pulse
module demux_scan_ctrl
    import demux_scan_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [2**N-1:0]    mask,
    output logic [N-1:0]       sel,
    output logic               in,
    output logic               busy,
    output logic               done
);
    localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);
    state_t              r_state, w_state;
    logic [N-1:0]        r_sel, w_sel;
    logic                r_in, w_in, r_busy, w_busy, r_done, w_done, r_loop, w_loop;
    logic [DWELL_W-1:0]  r_cnt, w_cnt, r_dwell, w_dwell, w_dwell_eff;
    logic [2**N-1:0]     r_mask, w_mask, w_scan_mask;
    logic [N-1:0]        w_next, w_lowest;
    logic                w_found;
    // In IDLE the finder looks at the live mask so start can pick the first channel directly.
    assign w_scan_mask = (r_state == SCAN) ? r_mask : mask;
    assign w_dwell_eff = (dwell == '0) ? ONE : dwell;
    next_chan_find #(.N(N)) u_find (
        .i_mask         (w_scan_mask),
        .i_sel          (r_sel),
        .o_next         (w_next),
        .o_found_higher (w_found),
        .o_lowest       (w_lowest)
    );
    always_comb begin
        w_state = r_state;
        w_sel   = r_sel;
        w_in    = r_in;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_cnt   = r_cnt;
        w_mask  = r_mask;
        w_loop  = r_loop;
        w_dwell = r_dwell;
        case (r_state)
            IDLE: begin
                if (start && !stop && |mask) begin
                    w_mask  = mask;
                    w_loop  = loop;
                    w_dwell = w_dwell_eff;
                    w_sel   = w_lowest;
                    w_cnt   = w_dwell_eff - ONE;
                    w_in    = 1'b1;
                    w_busy  = 1'b1;
                    w_state = SCAN;
                end
            end
            default: begin
                if (stop) begin
                    w_in    = 1'b0;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt = r_cnt - ONE;
                end else if (w_found || r_loop) begin
                    w_sel = w_found ? w_next : w_lowest;
                    w_cnt = r_dwell - ONE;
                end else begin
                    w_in    = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_in    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_loop  <= 1'b0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state;
            r_sel   <= w_sel;
            r_in    <= w_in;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_cnt   <= w_cnt;
            r_mask  <= w_mask;
            r_loop  <= w_loop;
            r_dwell <= w_dwell;
        end
    end
    assign sel  = r_sel;
    assign in   = r_in;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_demux_scan_ctrl.sv
// tb_demux_scan_ctrl: directed and randomized checks of demux_scan_ctrl against a channel-list model.
module tb_demux_scan_ctrl;
    localparam int N  = 3;
    localparam int CH = 8;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [7:0] dwell = '0, mask = '0;
    logic [2:0] sel;
    logic       in, busy, done;
    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;
    demux_scan_ctrl #(.N(N), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
        .dwell(dwell), .mask(mask), .sel(sel), .in(in), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: a sweep is the ascending list of enabled channels, each shown D cycles;
    // m_t counts elapsed cycles since start, so sel = chans[m_t / D].
    bit m_active = 1'b0, m_done = 1'b0, m_loop = 1'b0;
    int m_sel = 0, m_t = 0, m_d = 1, m_len = 0;
    int m_chans[$];
    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_sel = 0;
        end else if (!m_active) begin
            if (start && !stop && mask != 0) begin
                m_chans.delete();
                for (int c = 0; c < CH; c++) if (mask[c]) m_chans.push_back(c);
                m_d = (dwell == 0) ? 1 : int'(dwell);
                m_loop = loop;
                m_len = m_chans.size() * m_d;
                m_t = 0;
                m_active = 1'b1;
                m_sel = m_chans[0];
            end
        end else if (stop) begin
            m_active = 1'b0;
        end else begin
            m_t++;
            if (m_t == m_len) begin
                if (m_loop) m_t = 0;
                else begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (m_active) m_sel = m_chans[m_t / m_d];
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_sel", 32'(sel), 32'(m_sel));
            chk("model_in", 32'(in), 32'(m_active));
            chk("model_busy", 32'(busy), 32'(m_active));
            chk("model_done", 32'(done), 32'(m_done));
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic launch(input logic [7:0] m, input logic [7:0] d, input logic l);
        mask = m; dwell = d; loop = l; start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask
    int exp1[8] = '{0, 0, 2, 2, 5, 5, 7, 7};
    initial begin
        cyc(1);
        chk_en = 1'b1;
        chk("rst_sel", 32'(sel), 0);
        chk("rst_in", 32'(in), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        launch(8'hA5, 8'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("t1_sel", 32'(sel), 32'(exp1[i]));
            chk("t1_in", 32'(in), 1);
            chk("t1_onehot_y", 32'(in ? (8'd1 << sel) : 8'd0), 32'(8'd1 << exp1[i]));
            cyc(1);
        end
        chk("t1_done", 32'(done), 1);
        chk("t1_in_end", 32'(in), 0);
        chk("t1_busy_end", 32'(busy), 0);
        cyc(2);
        launch(8'h12, 8'd0, 1'b0);
        chk("t2_sel0", 32'(sel), 1);
        cyc(1);
        chk("t2_sel1", 32'(sel), 4);
        cyc(1);
        chk("t2_done", 32'(done), 1);
        cyc(2);
        launch(8'h81, 8'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_sel", 32'(sel), (i % 2 == 0) ? 0 : 7);
            if (i < 3) cyc(1);
        end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t3_stop_in", 32'(in), 0);
        chk("t3_stop_busy", 32'(busy), 0);
        chk("t3_stop_done", 32'(done), 0);
        chk("t3_stop_sel", 32'(sel), 7);
        mask = 8'h00; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t4_mask0_busy", 32'(busy), 0);
            chk("t4_mask0_done", 32'(done), 0);
        end
        mask = 8'hFF; stop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            chk("t4_startstop_busy", 32'(busy), 0);
        end
        start = 1'b0; stop = 1'b0;
        cyc(1);
        launch(8'hA5, 8'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("t5_sel", 32'(sel), 32'(exp1[i]));
            mask = 8'($urandom);
            dwell = 8'($urandom);
            start = 1'($urandom);
            loop = 1'($urandom);
            cyc(1);
        end
        chk("t5_done", 32'(done), 1);
        start = 1'b0;
        cyc(2);
        launch(8'hA5, 8'd3, 1'b0);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_rst_sel", 32'(sel), 0);
        chk("t6_rst_in", 32'(in), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_done", 32'(done), 0);
        cyc(1);
        mask = 8'h12; dwell = 8'd1; loop = 1'b0; start = 1'b1;
        cyc(3);
        chk("t7_done", 32'(done), 1);
        cyc(1);
        chk("t7_restart_sel", 32'(sel), 1);
        chk("t7_restart_busy", 32'(busy), 1);
        start = 1'b0;
        cyc(4);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            stop = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 3) == 0);
            loop = ($urandom_range(0, 3) == 0);
            mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            dwell = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 3));
            cyc(1);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
